rtc_bcd_clock: RTL and testbench

Free-running BCD calendar clock that sits directly downstream of the MCP7940N I2C RTC reader. It loads the reader's 56-bit BCD datetime on each valid-data tick and, between loads, advances its own copy once per second with full BCD carry logic: seconds, minutes, hours, weekday, day, month-length and leap-year-aware month, and year. This gives the rest of the design a datetime that changes on a clean, exact 1 s pulse. It does not depend on the reader's irregular register-polling rate.

---
 rtl/rtc_bcd_clock.sv | 155 +++++++++++++++
 tb/tb_rtc_bcd_clock.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_clock.sv
// BCD calendar clock: loads a datetime from the RTC reader and advances it once per
// prescaler period, walking the carry chain one field per clock cycle.
module rtc_bcd_clock #(
  parameter int c_clk_mhz = 25,
  parameter int c_div     = c_clk_mhz * 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [55:0] datetime_i,
  output logic [55:0] datetime_o,
  output logic        pps,
  output logic        busy,
  output logic        valid
);

  localparam int c_pre_w = (c_div > 2) ? $clog2(c_div) : 1;
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(c_div - 1);

  // idle: wait for terminal count | sec..year: carry walk, one field per cycle
  typedef enum logic [2:0] {
    st_idle, st_sec, st_min, st_hour, st_day, st_mon, st_year
  } state_t;

  state_t             state;
  logic [c_pre_w-1:0] prescaler;
  logic [7:0]         yy, mo, dd, wd, hh, mi, ss;
  logic               tc;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Binary YY mod 4 == 0 expressed on BCD digits: tens parity selects the unit set.
  function automatic logic is_leap(input logic [7:0] y);
    if (y[4]) return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    else      return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
  endfunction

  function automatic logic [7:0] last_day(input logic [7:0] m, input logic [7:0] y);
    case (m)
      8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  assign tc         = (prescaler == c_pre_max);
  assign datetime_o = {yy, mo, dd, wd, hh, mi, ss};

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      state     <= st_idle;
      yy        <= 8'h00;
      mo        <= 8'h01;
      dd        <= 8'h01;
      wd        <= 8'h01;
      hh        <= 8'h00;
      mi        <= 8'h00;
      ss        <= 8'h00;
      pps       <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      pps <= 1'b0;
      if (load || tc) prescaler <= '0;
      else            prescaler <= prescaler + c_pre_w'(1);

      if (load) begin
        {yy, mo, dd, wd, hh, mi, ss} <= datetime_i;
        state <= st_idle;
        busy  <= 1'b0;
        valid <= 1'b1;
      end else begin
        case (state)
          st_idle: begin
            if (tc) begin
              state <= st_sec;
              busy  <= 1'b1;
            end
          end
          st_sec: begin
            if (ss == 8'h59) begin
              ss    <= 8'h00;
              state <= st_min;
            end else begin
              ss    <= bcd_inc(ss);
              state <= st_idle;
              busy  <= 1'b0;
              pps   <= 1'b1;
            end
          end
          st_min: begin
            if (mi == 8'h59) begin
              mi    <= 8'h00;
              state <= st_hour;
            end else begin
              mi    <= bcd_inc(mi);
              state <= st_idle;
              busy  <= 1'b0;
              pps   <= 1'b1;
            end
          end
          st_hour: begin
            if (hh == 8'h23) begin
              hh    <= 8'h00;
              state <= st_day;
            end else begin
              hh    <= bcd_inc(hh);
              state <= st_idle;
              busy  <= 1'b0;
              pps   <= 1'b1;
            end
          end
          st_day: begin
            // Weekday moves on every day carry, independent of the month wrap.
            wd <= (wd == 8'h07) ? 8'h01 : bcd_inc(wd);
            if (dd == last_day(mo, yy)) begin
              dd    <= 8'h01;
              state <= st_mon;
            end else begin
              dd    <= bcd_inc(dd);
              state <= st_idle;
              busy  <= 1'b0;
              pps   <= 1'b1;
            end
          end
          st_mon: begin
            if (mo == 8'h12) begin
              mo    <= 8'h01;
              state <= st_year;
            end else begin
              mo    <= bcd_inc(mo);
              state <= st_idle;
              busy  <= 1'b0;
              pps   <= 1'b1;
            end
          end
          st_year: begin
            yy    <= (yy == 8'h99) ? 8'h00 : bcd_inc(yy);
            state <= st_idle;
            busy  <= 1'b0;
            pps   <= 1'b1;
          end
          default: begin
            state <= st_idle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_bcd_clock.sv
// Bench for rtc_bcd_clock: calendar model in plain integer arithmetic, checked every
// cycle, plus directed boundary cases pinned with literal datetimes.
module tb_rtc_bcd_clock;
  localparam int          c_div    = 16;
  localparam logic [55:0] c_rst_dt = 56'h00_01_01_01_00_00_00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [55:0] datetime_i = '0;
  logic [55:0] datetime_o;
  logic        pps, busy, valid;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int          m_pre, m_walk;
  logic        m_busy, m_pps, m_valid;
  logic [55:0] m_dt, m_next;

  rtc_bcd_clock #(.c_div(c_div)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .datetime_i (datetime_i),
    .datetime_o (datetime_o),
    .pps        (pps),
    .busy       (busy),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int bcd2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int days_in(input int mo, input int yy);
    case (mo)
      2:             return (yy % 4 == 0) ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  function automatic logic [55:0] add_second(input logic [55:0] d);
    int yy = bcd2i(d[55:48]);
    int mo = bcd2i(d[47:40]);
    int dd = bcd2i(d[39:32]);
    int wd = bcd2i(d[31:24]);
    int hh = bcd2i(d[23:16]);
    int mi = bcd2i(d[15:8]);
    int ss = bcd2i(d[7:0]);
    ss++;
    if (ss == 60) begin
      ss = 0; mi++;
      if (mi == 60) begin
        mi = 0; hh++;
        if (hh == 24) begin
          hh = 0; dd++; wd = wd % 7 + 1;
          if (dd > days_in(mo, yy)) begin
            dd = 1; mo++;
            if (mo == 13) begin
              mo = 1; yy = (yy + 1) % 100;
            end
          end
        end
      end
    end
    return {to_bcd(yy), to_bcd(mo), to_bcd(dd), to_bcd(wd), to_bcd(hh), to_bcd(mi), to_bcd(ss)};
  endfunction

  // Number of fields touched by one second: one per carry plus the final increment.
  function automatic int walk_len(input logic [55:0] d);
    int n = 1;
    if (bcd2i(d[7:0]) == 59) begin
      n = 2;
      if (bcd2i(d[15:8]) == 59) begin
        n = 3;
        if (bcd2i(d[23:16]) == 23) begin
          n = 4;
          if (bcd2i(d[39:32]) == days_in(bcd2i(d[47:40]), bcd2i(d[55:48]))) begin
            n = 5;
            if (bcd2i(d[47:40]) == 12) n = 6;
          end
        end
      end
    end
    return n;
  endfunction

  function automatic logic [55:0] rand_dt();
    int yy = $urandom_range(99, 0);
    int mo = $urandom_range(12, 1);
    int dd = $urandom_range(days_in(mo, yy), 1);
    int wd = $urandom_range(7, 1);
    int hh = $urandom_range(23, 0);
    int mi = $urandom_range(59, 0);
    int ss = $urandom_range(59, 0);
    if ($urandom_range(1, 0) == 1) ss = 59;
    if ($urandom_range(1, 0) == 1) mi = 59;
    if ($urandom_range(2, 0) != 0) hh = 23;
    if ($urandom_range(1, 0) == 1) dd = days_in(mo, yy);
    if ($urandom_range(2, 0) == 0) mo = 12;
    if ($urandom_range(3, 0) == 0) begin mo = 2; dd = days_in(2, yy); end
    return {to_bcd(yy), to_bcd(mo), to_bcd(dd), to_bcd(wd), to_bcd(hh), to_bcd(mi), to_bcd(ss)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic rst, input logic ld, input logic [55:0] din);
    logic tc;
    reset      = rst;
    load       = ld;
    datetime_i = din;
    @(posedge clk);
    if (rst) begin
      m_dt = c_rst_dt; m_pre = 0; m_walk = 0;
      m_busy = 1'b0; m_pps = 1'b0; m_valid = 1'b0;
    end else begin
      tc    = (m_pre == c_div - 1);
      m_pps = 1'b0;
      m_pre = (ld || tc) ? 0 : m_pre + 1;
      if (ld) begin
        m_dt = din; m_walk = 0; m_busy = 1'b0; m_valid = 1'b1;
      end else if (m_walk > 0) begin
        m_walk--;
        if (m_walk == 0) begin
          m_busy = 1'b0; m_pps = 1'b1; m_dt = m_next;
        end
      end else if (tc) begin
        m_walk = walk_len(m_dt);
        m_next = add_second(m_dt);
        m_busy = 1'b1;
      end
    end
    @(negedge clk);
    check("pps", 64'(pps), 64'(m_pps));
    check("busy", 64'(busy), 64'(m_busy));
    check("valid", 64'(valid), 64'(m_valid));
    if (!m_busy) check("datetime", 64'(datetime_o), 64'(m_dt));
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0, {$urandom, $urandom});
  endtask

  // Load, wait for the next terminal count, then watch the walk to its pps.
  task automatic tick_case(input string name, input logic [55:0] din,
                           input logic [55:0] exp, input int exp_busy);
    int   bc   = 0;
    logic seen = 1'b0;
    step(1'b0, 1'b1, din);
    check({name, "_load"}, 64'(datetime_o), 64'(din));
    check({name, "_valid"}, 64'(valid), 64'd1);
    run(15);
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 1'b0, {$urandom, $urandom});
      if (busy) bc++;
      if (pps) seen = 1'b1;
    end
    check({name, "_pps_seen"}, 64'(seen), 64'd1);
    check({name, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
    check({name, "_result"}, 64'(datetime_o), 64'(exp));
  endtask

  initial begin
    int bc, pc;

    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("reset_dt", 64'(datetime_o), 64'(c_rst_dt));
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_pps", 64'(pps), 64'd0);
    run(20);

    tick_case("ss_30_31",  56'h25_06_15_03_10_20_30, 56'h25_06_15_03_10_20_31, 1);
    tick_case("ss_39_40",  56'h25_06_15_03_10_20_39, 56'h25_06_15_03_10_20_40, 1);
    tick_case("full_roll", 56'h99_12_31_07_23_59_59, 56'h00_01_01_01_00_00_00, 6);
    tick_case("leap_2824", 56'h24_02_28_04_23_59_59, 56'h24_02_29_05_00_00_00, 4);
    tick_case("nonleap23", 56'h23_02_28_02_23_59_59, 56'h23_03_01_03_00_00_00, 5);
    tick_case("leap_2900", 56'h00_02_29_06_23_59_59, 56'h00_03_01_07_00_00_00, 5);
    tick_case("apr_30",    56'h25_04_30_05_23_59_59, 56'h25_05_01_06_00_00_00, 5);

    // load on the terminal-count cycle
    step(1'b0, 1'b1, 56'h25_06_15_03_10_20_30);
    run(15);
    step(1'b0, 1'b1, 56'h25_06_15_03_10_20_00);
    check("tc_load_dt", 64'(datetime_o), 64'h25_06_15_03_10_20_00);
    bc = 0; pc = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, {$urandom, $urandom});
      if (busy) bc++;
      if (pps) pc++;
    end
    check("tc_load_no_pps", 64'(pc), 64'd0);
    check("tc_load_no_busy", 64'(bc), 64'd0);
    check("tc_load_hold", 64'(datetime_o), 64'h25_06_15_03_10_20_00);
    run(2);
    check("tc_load_next_pps", 64'(pps), 64'd1);
    check("tc_load_next_dt", 64'(datetime_o), 64'h25_06_15_03_10_20_01);

    // load aborting a full rollover mid-walk
    step(1'b0, 1'b1, 56'h99_12_31_07_23_59_59);
    run(18);
    step(1'b0, 1'b1, 56'h12_07_04_04_12_00_00);
    check("abort_load_dt", 64'(datetime_o), 64'h12_07_04_04_12_00_00);
    pc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, {$urandom, $urandom});
      if (pps) pc++;
    end
    check("abort_load_no_pps", 64'(pc), 64'd0);
    check("abort_load_hold", 64'(datetime_o), 64'h12_07_04_04_12_00_00);

    // reset aborting a full rollover mid-walk
    step(1'b0, 1'b1, 56'h99_12_31_07_23_59_59);
    run(18);
    step(1'b1, 1'b0, '0);
    check("abort_rst_dt", 64'(datetime_o), 64'(c_rst_dt));
    check("abort_rst_valid", 64'(valid), 64'd0);
    pc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, {$urandom, $urandom});
      if (pps) pc++;
    end
    check("abort_rst_no_pps", 64'(pc), 64'd0);

    // random loads, resets and free-running ticks against the model
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(99, 0);
      if (r == 0)     step(1'b1, 1'b0, {$urandom, $urandom});
      else if (r < 4) step(1'b0, 1'b1, rand_dt());
      else            step(1'b0, 1'b0, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
